// File: rtl/pc_gen.sv
// pc_gen: registered fetch-address generator with prioritised next-PC sources.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int INSTR_BYTES = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] INC = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] LOW = XLEN'(INSTR_BYTES - 1);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            mis_q;
  logic            mis_d;
  logic [XLEN-1:0] pc_seq;
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;

  assign pc_seq = pc_q + INC;

`ifdef PC_RAS_EN
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   top_q;
  logic [PW-1:0]   top_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [PW-1:0]   wr_idx;
  logic            wr_en;
  logic            go;
  logic            do_push;
  logic            do_pop;

  assign go      = !reset && !trap_valid
                && !redirect_valid && !stall;
  assign do_push = go && call_push;
  assign do_pop  = go && ret_pop && (cnt_q != '0);
  assign ras_hit = do_pop;
  assign ras_top = ras_q[top_q];
  assign ras_empty = (cnt_q == '0);

  // Stack pointer/count update; push+pop replaces the top in place.
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (do_push && do_pop) begin
      wr_en = 1'b1;
    end else if (do_push) begin
      wr_idx = top_q + 1'b1;
      top_d  = wr_idx;
      wr_en  = 1'b1;
      cnt_d  = (cnt_q == FULL) ? cnt_q
                               : cnt_q + 1'b1;
    end else if (do_pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack storage; circular, so a full push overwrites the oldest.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_q[wr_idx] <= pc_seq;
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_ras;

  assign unused_ras = call_push ^ ret_pop
                    ^ (PW == 0);
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
`endif

  // Next-PC selection in priority order.
  always_comb begin
    pc_next = pc_seq;
    mis_d   = 1'b0;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else if (trap_valid) begin
      pc_next = trap_vector & ~LOW;
      mis_d   = |(trap_vector & LOW);
    end else if (redirect_valid) begin
      pc_next = redirect_target & ~LOW;
      mis_d   = |(redirect_target & LOW);
    end else if (ras_hit) begin
      pc_next = ras_top;
    end else if (stall) begin
      pc_next = pc_q;
    end
  end

  // Fetch address, valid and misalignment flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      valid_q <= 1'b1;
      mis_q   <= mis_d;
    end
  end

  assign pc_out     = pc_q;
  assign pc_valid   = valid_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plan plus random stimulus checked against a
// queue-based reference model of the PC generator.
module tb_pc_gen;

  localparam int XLEN = 64;
  localparam logic [63:0] RV = 64'h1000;
  localparam int IB = 4;
  localparam int D = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        trap_valid;
  logic [63:0] trap_vector;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        call_push;
  logic        ret_pop;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic [63:0] pc_next;
  logic        misaligned;
  logic        ras_empty;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN(XLEN),
    .RESET_VECTOR(RV),
    .INSTR_BYTES(IB),
    .RAS_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .trap_valid(trap_valid),
    .trap_vector(trap_vector),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .call_push(call_push),
    .ret_pop(ret_pop),
    .pc_out(pc_out),
    .pc_valid(pc_valid),
    .pc_next(pc_next),
    .misaligned(misaligned),
    .ras_empty(ras_empty)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic [63:0] m_ras [$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] align(input logic [63:0] a);
    return (a / IB) * IB;
  endfunction

  function automatic logic [63:0] model_next();
    if (reset) return RV;
    if (trap_valid) return align(trap_vector);
    if (redirect_valid) return align(redirect_target);
    if (RAS_ON && !stall && ret_pop && m_ras.size() > 0)
      return m_ras[$];
    if (stall) return m_pc;
    return m_pc + IB;
  endfunction

  task automatic idle();
    reset = 1'b0;
    stall = 1'b0;
    trap_valid = 1'b0;
    trap_vector = '0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    call_push = 1'b0;
    ret_pop = 1'b0;
  endtask

  task automatic tick();
    logic [63:0] exp_next;
    logic        exp_empty;
    #1;
    exp_next = model_next();
    check("pc_next", pc_next, exp_next);
    @(posedge clk);
    if (reset) begin
      m_pc = RV;
      m_valid = 1'b0;
      m_mis = 1'b0;
      m_ras.delete();
    end else begin
      if (trap_valid)
        m_mis = (trap_vector % IB) != 0;
      else if (redirect_valid)
        m_mis = (redirect_target % IB) != 0;
      else
        m_mis = 1'b0;
      if (RAS_ON && !trap_valid && !redirect_valid && !stall) begin
        if (ret_pop && m_ras.size() > 0)
          void'(m_ras.pop_back());
        if (call_push) begin
          m_ras.push_back(m_pc + IB);
          if (m_ras.size() > D)
            void'(m_ras.pop_front());
        end
      end
      m_pc = exp_next;
      m_valid = 1'b1;
    end
    #1;
    exp_empty = !RAS_ON || (m_ras.size() == 0);
    check("pc_out", pc_out, m_pc);
    check("pc_valid", 64'(pc_valid), 64'(m_valid));
    check("misaligned", 64'(misaligned), 64'(m_mis));
    check("ras_empty", 64'(ras_empty), 64'(exp_empty));
  endtask

  task automatic redir(input logic [63:0] t);
    idle();
    redirect_valid = 1'b1;
    redirect_target = t;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    check("rst_pc", pc_out, 64'h1000);
    check("rst_valid", 64'(pc_valid), 64'd0);
    check("rst_empty", 64'(ras_empty), 64'd1);
    idle();
    tick();
    check("seq1", pc_out, 64'h1004);
    check("seq1_valid", 64'(pc_valid), 64'd1);
    tick();
    check("seq2", pc_out, 64'h1008);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", pc_out, 64'h1008);
    end
    redirect_valid = 1'b1;
    redirect_target = 64'h2002;
    tick();
    check("redir_pc", pc_out, 64'h2000);
    check("redir_mis", 64'(misaligned), 64'd1);
    idle();
    tick();
    check("mis_clear", 64'(misaligned), 64'd0);
    check("after_redir", pc_out, 64'h2004);

    trap_valid = 1'b1;
    trap_vector = 64'h8000;
    redirect_valid = 1'b1;
    redirect_target = 64'h3000;
    tick();
    check("trap_pc", pc_out, 64'h8000);
    check("trap_mis", 64'(misaligned), 64'd0);
    idle();

    redir(64'h3000);
    redir(64'h3000);
    check("redir_hold", pc_out, 64'h3000);

`ifdef PC_RAS_EN
    redir(64'h1000);
    call_push = 1'b1;
    tick();
    redir(64'h2000);
    call_push = 1'b1;
    tick();
    call_push = 1'b0;
    ret_pop = 1'b1;
    tick();
    check("pop1", pc_out, 64'h2004);
    tick();
    check("pop2", pc_out, 64'h1004);
    check("pop2_empty", 64'(ras_empty), 64'd1);
    tick();
    check("pop3_seq", pc_out, 64'h1008);
    idle();

    redir(64'h4000);
    call_push = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    call_push = 1'b0;
    ret_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("deep_pop", pc_out, 64'h4014 - 64'(4 * k));
    end
    check("deep_empty", 64'(ras_empty), 64'd1);
    tick();
    check("deep_seq", pc_out, 64'h400C);
    idle();
`endif

    redir(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap0", pc_out, 64'h0);
    tick();
    check("wrap4", pc_out, 64'h4);

    reset = 1'b1;
    stall = 1'b1;
    trap_valid = 1'b1;
    trap_vector = 64'h9000;
    tick();
    check("mid_rst", pc_out, 64'h1000);
    check("mid_rst_v", 64'(pc_valid), 64'd0);
    idle();
    tick();

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      trap_valid = ($urandom_range(0, 19) == 0);
      trap_vector = {$urandom, $urandom};
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_target = {$urandom, $urandom};
      stall = ($urandom_range(0, 3) == 0);
      call_push = ($urandom_range(0, 2) == 0);
      ret_pop = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
